// File: rtl/acortex_sram_arb.sv
// Arbiter for the external async SRAM: a circular FIFO port for the audio path plus a
// memory-mapped port for the local-bus register block, with 2-cycle SRAM accesses.
module acortex_sram_arb #(
    parameter int P_DATA_W        = 16,
    parameter int P_SRAM_ADDR_W   = 18,
    parameter int P_AEMPTY_THRESH = 64
) (
    input  logic                     clk_ir,
    input  logic                     rst_ih,
    input  logic                     ff_wr_en_ih,
    input  logic [P_DATA_W-1:0]      ff_wr_data_id,
    input  logic                     ff_rd_en_ih,
    output logic                     ff_rd_valid_od,
    output logic [P_DATA_W-1:0]      ff_rd_data_od,
    output logic                     ff_full_oh,
    output logic                     ff_empty_oh,
    output logic                     ff_aempty_oh,
    output logic                     ff_err_oh,
    input  logic                     mm_rd_en_ih,
    input  logic                     mm_wr_en_ih,
    input  logic [P_SRAM_ADDR_W-1:0] mm_addr_id,
    input  logic [P_DATA_W-1:0]      mm_wr_data_id,
    output logic                     mm_rd_valid_od,
    output logic [P_DATA_W-1:0]      mm_rd_data_od,
    output logic                     mm_grant_oh,
    output logic [P_SRAM_ADDR_W-1:0] sram_addr_od,
    inout  wire  [P_DATA_W-1:0]      sram_dq_iod,
    output logic                     sram_ce_ol,
    output logic                     sram_oe_ol,
    output logic                     sram_we_ol,
    output logic                     sram_ub_ol,
    output logic                     sram_lb_ol
);

    typedef enum logic [3:0] {
        S_IDLE, S_FWR1, S_FWR2, S_FRD1, S_FRD2, S_MWR1, S_MWR2, S_MRD1, S_MRD2
    } state_t;

    localparam logic [P_SRAM_ADDR_W:0] LP_DEPTH  = {1'b1, {P_SRAM_ADDR_W{1'b0}}};
    localparam logic [P_SRAM_ADDR_W:0] LP_AEMPTY = P_AEMPTY_THRESH[P_SRAM_ADDR_W:0];

    state_t                   state, state_nx;
    logic [P_SRAM_ADDR_W:0]   occ;
    logic [P_SRAM_ADDR_W-1:0] wr_ptr, rd_ptr;
    logic                     wr_pend, rd_pend;
    logic [P_DATA_W-1:0]      wr_pend_data;
    logic                     dq_oe;
    logic [P_DATA_W-1:0]      dq_out;

    logic occ_full, occ_empty, wr_acc, rd_acc, req_collide;

    // Full/empty gating uses the pre-update occupancy, not the registered status.
    assign occ_full    = (occ == LP_DEPTH);
    assign occ_empty   = (occ == '0);
    assign wr_acc      = ff_wr_en_ih && !occ_full  && !wr_pend;
    assign rd_acc      = ff_rd_en_ih && !occ_empty && !rd_pend;
    assign req_collide = (ff_wr_en_ih && !occ_full && wr_pend) ||
                         (ff_rd_en_ih && !occ_empty && rd_pend);

    assign sram_dq_iod = dq_oe ? dq_out : {P_DATA_W{1'bz}};
    assign sram_ub_ol  = 1'b0;
    assign sram_lb_ol  = 1'b0;

    // NOTE: state and registered outputs use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            wr_pend      <= 1'b0;
            rd_pend      <= 1'b0;
            wr_pend_data <= '0;
            occ          <= '0;
            ff_err_oh    <= 1'b0;
            ff_full_oh   <= 1'b0;
            ff_empty_oh  <= 1'b1;
            ff_aempty_oh <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_pend      <= 1'b1;
                wr_pend_data <= ff_wr_data_id;
            end else if (state == S_FWR2) begin
                wr_pend <= 1'b0;
            end
            if (rd_acc) begin
                rd_pend <= 1'b1;
            end else if (state == S_FRD2) begin
                rd_pend <= 1'b0;
            end
            if (req_collide) begin
                ff_err_oh <= 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase
            ff_full_oh   <= occ_full;
            ff_empty_oh  <= occ_empty;
            ff_aempty_oh <= (occ <= LP_AEMPTY);
        end
    end

    // NOTE: next state defaults to the current state before the case, so no path
    // leaves state_nx unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (wr_pend) begin
                    state_nx = S_FWR1;
                end else if (rd_pend) begin
                    state_nx = S_FRD1;
                end else if (!mm_rd_valid_od) begin
                    // The MM requester drops its enable one cycle after read valid.
                    if (mm_wr_en_ih) begin
                        state_nx = S_MWR1;
                    end else if (mm_rd_en_ih) begin
                        state_nx = S_MRD1;
                    end
                end
            end
            S_FWR1:  state_nx = S_FWR2;
            S_FRD1:  state_nx = S_FRD2;
            S_MWR1:  state_nx = S_MWR2;
            S_MRD1:  state_nx = S_MRD2;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ir or posedge rst_ih) begin
        if (rst_ih) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            sram_addr_od   <= '0;
            sram_ce_ol     <= 1'b1;
            sram_oe_ol     <= 1'b1;
            sram_we_ol     <= 1'b1;
            dq_oe          <= 1'b0;
            dq_out         <= '0;
            mm_grant_oh    <= 1'b0;
            ff_rd_valid_od <= 1'b0;
            ff_rd_data_od  <= '0;
            mm_rd_valid_od <= 1'b0;
            mm_rd_data_od  <= '0;
        end else begin
            state          <= state_nx;
            sram_ce_ol     <= 1'b1;
            sram_oe_ol     <= 1'b1;
            sram_we_ol     <= 1'b1;
            dq_oe          <= 1'b0;
            mm_grant_oh    <= 1'b0;
            ff_rd_valid_od <= (state == S_FRD2);
            mm_rd_valid_od <= (state == S_MRD2);
            // Strobes are set up from the next state so they are valid in the x1 cycle.
            case (state_nx)
                S_FWR1: begin
                    sram_ce_ol   <= 1'b0;
                    sram_we_ol   <= 1'b0;
                    dq_oe        <= 1'b1;
                    sram_addr_od <= wr_ptr;
                    dq_out       <= wr_pend_data;
                end
                S_MWR1: begin
                    sram_ce_ol   <= 1'b0;
                    sram_we_ol   <= 1'b0;
                    dq_oe        <= 1'b1;
                    sram_addr_od <= mm_addr_id;
                    dq_out       <= mm_wr_data_id;
                    mm_grant_oh  <= 1'b1;
                end
                S_FWR2, S_MWR2: begin
                    sram_ce_ol <= 1'b0;
                    dq_oe      <= 1'b1;
                end
                S_FRD1: begin
                    sram_ce_ol   <= 1'b0;
                    sram_oe_ol   <= 1'b0;
                    sram_addr_od <= rd_ptr;
                end
                S_MRD1: begin
                    sram_ce_ol   <= 1'b0;
                    sram_oe_ol   <= 1'b0;
                    sram_addr_od <= mm_addr_id;
                    mm_grant_oh  <= 1'b1;
                end
                S_FRD2, S_MRD2: begin
                    sram_ce_ol <= 1'b0;
                    sram_oe_ol <= 1'b0;
                end
                default: ;
            endcase
            if (state == S_FWR2) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (state == S_FRD2) begin
                rd_ptr        <= rd_ptr + 1'b1;
                ff_rd_data_od <= sram_dq_iod;
            end
            if (state == S_MRD2) begin
                mm_rd_data_od <= sram_dq_iod;
            end
        end
    end

endmodule

// File: tb/tb_acortex_sram_arb.sv
// Directed + randomized bench for acortex_sram_arb with a small-depth instance, an
// async SRAM model on the bus, and a pointer/occupancy/memory reference model.
module tb_acortex_sram_arb;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int TH    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk_ir = 1'b0;
    logic          rst_ih = 1'b1;
    logic          ff_wr_en_ih = 1'b0;
    logic [DW-1:0] ff_wr_data_id = '0;
    logic          ff_rd_en_ih = 1'b0;
    logic          ff_rd_valid_od;
    logic [DW-1:0] ff_rd_data_od;
    logic          ff_full_oh, ff_empty_oh, ff_aempty_oh, ff_err_oh;
    logic          mm_rd_en_ih = 1'b0;
    logic          mm_wr_en_ih = 1'b0;
    logic [AW-1:0] mm_addr_id = '0;
    logic [DW-1:0] mm_wr_data_id = '0;
    logic          mm_rd_valid_od;
    logic [DW-1:0] mm_rd_data_od;
    logic          mm_grant_oh;
    logic [AW-1:0] sram_addr_od;
    wire  [DW-1:0] sram_dq_iod;
    logic          sram_ce_ol, sram_oe_ol, sram_we_ol, sram_ub_ol, sram_lb_ol;

    always #5 clk_ir = ~clk_ir;

    acortex_sram_arb #(
        .P_DATA_W(DW), .P_SRAM_ADDR_W(AW), .P_AEMPTY_THRESH(TH)
    ) dut (
        .clk_ir(clk_ir), .rst_ih(rst_ih),
        .ff_wr_en_ih(ff_wr_en_ih), .ff_wr_data_id(ff_wr_data_id),
        .ff_rd_en_ih(ff_rd_en_ih), .ff_rd_valid_od(ff_rd_valid_od),
        .ff_rd_data_od(ff_rd_data_od), .ff_full_oh(ff_full_oh),
        .ff_empty_oh(ff_empty_oh), .ff_aempty_oh(ff_aempty_oh), .ff_err_oh(ff_err_oh),
        .mm_rd_en_ih(mm_rd_en_ih), .mm_wr_en_ih(mm_wr_en_ih),
        .mm_addr_id(mm_addr_id), .mm_wr_data_id(mm_wr_data_id),
        .mm_rd_valid_od(mm_rd_valid_od), .mm_rd_data_od(mm_rd_data_od),
        .mm_grant_oh(mm_grant_oh), .sram_addr_od(sram_addr_od),
        .sram_dq_iod(sram_dq_iod), .sram_ce_ol(sram_ce_ol), .sram_oe_ol(sram_oe_ol),
        .sram_we_ol(sram_we_ol), .sram_ub_ol(sram_ub_ol), .sram_lb_ol(sram_lb_ol)
    );

    // Async SRAM: drives the bus while selected for read, stores on the rising edge of WE.
    logic [DW-1:0] sram_mem [DEPTH];
    assign sram_dq_iod = (!sram_ce_ol && !sram_oe_ol) ? sram_mem[sram_addr_od] : {DW{1'bz}};
    always @(posedge sram_we_ol) begin
        if (sram_ce_ol === 1'b0) sram_mem[sram_addr_od] <= sram_dq_iod;
    end

    // Reference model: SRAM contents, FIFO pointers, occupancy, sticky error.
    logic [DW-1:0] model_mem [DEPTH];
    int            m_wr_ptr = 0;
    int            m_rd_ptr = 0;
    int            m_occ    = 0;
    logic          exp_err  = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_ir);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_empty"},  ff_empty_oh,  (m_occ == 0)     ? 1 : 0);
        check({tag, "_full"},   ff_full_oh,   (m_occ == DEPTH) ? 1 : 0);
        check({tag, "_aempty"}, ff_aempty_oh, (m_occ <= TH)    ? 1 : 0);
        check({tag, "_err"},    ff_err_oh,    exp_err);
    endtask

    task automatic ff_write(input logic [DW-1:0] d);
        logic acc;
        acc = (m_occ < DEPTH);
        ff_wr_data_id = d;
        ff_wr_en_ih   = 1'b1;
        @(negedge clk_ir);
        ff_wr_en_ih = 1'b0;
        @(negedge clk_ir);
        if (acc) begin
            check("fwr1_we",   sram_we_ol,   0);
            check("fwr1_ce",   sram_ce_ol,   0);
            check("fwr1_addr", sram_addr_od, m_wr_ptr);
            check("fwr1_dq",   sram_dq_iod,  d);
        end else begin
            check("fwr_drop_we", sram_we_ol, 1);
        end
        @(negedge clk_ir);
        if (acc) begin
            check("fwr2_we_hold", sram_we_ol, 1);
            check("fwr2_dq_hold", sram_dq_iod, d);
            model_mem[m_wr_ptr] = d;
            m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
            m_occ++;
        end
        @(negedge clk_ir);
        check_status("fwr");
    endtask

    task automatic ff_read();
        logic          acc;
        logic [DW-1:0] e;
        acc = (m_occ > 0);
        e   = model_mem[m_rd_ptr];
        ff_rd_en_ih = 1'b1;
        @(negedge clk_ir);
        ff_rd_en_ih = 1'b0;
        @(negedge clk_ir);
        check("frd1_oe", sram_oe_ol, acc ? 0 : 1);
        if (acc) check("frd1_addr", sram_addr_od, m_rd_ptr);
        @(negedge clk_ir);
        check("frd_valid_early", ff_rd_valid_od, 0);
        @(negedge clk_ir);
        check("frd_valid", ff_rd_valid_od, acc);
        if (acc) check("frd_data", ff_rd_data_od, e);
        @(negedge clk_ir);
        check("frd_valid_late", ff_rd_valid_od, 0);
        if (acc) begin
            m_occ--;
            m_rd_ptr = (m_rd_ptr + 1) % DEPTH;
        end
        check_status("frd");
    endtask

    task automatic mm_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic got;
        got = 1'b0;
        mm_addr_id    = a;
        mm_wr_data_id = d;
        mm_wr_en_ih   = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk_ir);
            if (mm_grant_oh) got = 1'b1;
        end
        check("mwr_grant", got, 1);
        check("mwr1_we",   sram_we_ol,   0);
        check("mwr1_addr", sram_addr_od, a);
        check("mwr1_dq",   sram_dq_iod,  d);
        mm_wr_en_ih = 1'b0;
        @(negedge clk_ir);
        check("mwr_grant_pulse", mm_grant_oh, 0);
        model_mem[a] = d;
        tick(2);
    endtask

    task automatic mm_read(input logic [AW-1:0] a);
        int   grants, valids;
        logic got;
        grants = 0;
        valids = 0;
        got    = 1'b0;
        mm_addr_id  = a;
        mm_rd_en_ih = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk_ir);
            if (mm_grant_oh) grants++;
            if (mm_rd_valid_od) begin
                got = 1'b1;
                valids++;
                check("mrd_data", mm_rd_data_od, model_mem[a]);
            end
        end
        check("mrd_valid_seen", got, 1);
        // Enable stays high through the valid cycle, as the requester drops it late.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_ir);
            mm_rd_en_ih = 1'b0;
            if (mm_grant_oh) grants++;
            if (mm_rd_valid_od) valids++;
        end
        check("mrd_single_grant", grants, 1);
        check("mrd_single_valid", valids, 1);
    endtask

    initial begin
        logic [DW-1:0] d1, d2;
        logic          fwr_seen, grant_seen, rdv_seen;
        logic [DW-1:0] exp_rd;
        int            vcount;

        for (int i = 0; i < DEPTH; i++) begin
            sram_mem[i]  = '0;
            model_mem[i] = '0;
        end

        // Reset values.
        tick(3);
        check("rst_empty",  ff_empty_oh,  1);
        check("rst_aempty", ff_aempty_oh, 1);
        check("rst_full",   ff_full_oh,   0);
        check("rst_err",    ff_err_oh,    0);
        check("rst_ce",     sram_ce_ol,   1);
        check("rst_oe",     sram_oe_ol,   1);
        check("rst_we",     sram_we_ol,   1);
        check("rst_ublb",   {sram_ub_ol, sram_lb_ol}, 0);
        check("rst_addr",   sram_addr_od, 0);
        check("rst_valids", {ff_rd_valid_od, mm_rd_valid_od, mm_grant_oh}, 0);
        rst_ih = 1'b0;
        tick(2);
        check_status("post_rst");

        // First write: FWR1 one cycle after the pulse is taken, empty drops a cycle later.
        ff_wr_data_id = 16'hA5A5;
        ff_wr_en_ih   = 1'b1;
        @(negedge clk_ir);
        ff_wr_en_ih = 1'b0;
        check("t1_empty_still", ff_empty_oh, 1);
        check("t1_we_idle",     sram_we_ol,  1);
        @(negedge clk_ir);
        check("t1_we",    sram_we_ol,   0);
        check("t1_addr",  sram_addr_od, 0);
        check("t1_dq",    sram_dq_iod,  16'hA5A5);
        check("t1_empty", ff_empty_oh,  0);
        model_mem[0] = 16'hA5A5;
        m_wr_ptr = 1;
        m_occ    = 1;
        tick(2);
        check_status("t1");

        // Three words in, three out in order.
        ff_write(16'h1234);
        ff_write(16'hBEEF);
        ff_read();
        ff_read();
        ff_read();
        check("t2_last_data", ff_rd_data_od, 16'hBEEF);
        check("t2_empty", ff_empty_oh, 1);

        // Randomized mix of all four request kinds.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: ff_write(16'($urandom));
                1: ff_read();
                2: mm_write(AW'($urandom), 16'($urandom));
                default: mm_read(AW'($urandom));
            endcase
        end

        // FIFO write beats a simultaneously raised MM write while the FSM is busy.
        if (m_occ == 0) ff_write(16'h0F0F);
        exp_rd   = model_mem[m_rd_ptr];
        m_rd_ptr = (m_rd_ptr + 1) % DEPTH;
        m_occ--;
        ff_rd_en_ih = 1'b1;
        @(negedge clk_ir);
        ff_rd_en_ih = 1'b0;
        @(negedge clk_ir);
        check("t4_busy_oe", sram_oe_ol, 0);
        ff_wr_data_id = 16'h3C3C;
        ff_wr_en_ih   = 1'b1;
        mm_addr_id    = 5'h10;
        mm_wr_data_id = 16'h55AA;
        mm_wr_en_ih   = 1'b1;
        fwr_seen   = 1'b0;
        grant_seen = 1'b0;
        rdv_seen   = 1'b0;
        for (int i = 0; i < 16 && !grant_seen; i++) begin
            @(negedge clk_ir);
            ff_wr_en_ih = 1'b0;
            if (ff_rd_valid_od) begin
                rdv_seen = 1'b1;
                check("t4_rd_data", ff_rd_data_od, exp_rd);
            end
            if (!sram_we_ol && !fwr_seen && !grant_seen) begin
                fwr_seen = 1'b1;
                check("t4_fwr_nogrant", mm_grant_oh,  0);
                check("t4_fwr_addr",    sram_addr_od, m_wr_ptr);
                check("t4_fwr_dq",      sram_dq_iod,  16'h3C3C);
            end
            if (mm_grant_oh) begin
                grant_seen = 1'b1;
                check("t4_fifo_first", fwr_seen, 1);
                check("t4_mwr_we",     sram_we_ol,   0);
                check("t4_mwr_addr",   sram_addr_od, 5'h10);
                check("t4_mwr_dq",     sram_dq_iod,  16'h55AA);
                mm_wr_en_ih = 1'b0;
            end
        end
        mm_wr_en_ih = 1'b0;
        check("t4_grant_seen", grant_seen, 1);
        check("t4_rdv_seen",   rdv_seen,   1);
        model_mem[m_wr_ptr] = 16'h3C3C;
        m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
        m_occ++;
        model_mem[5'h10] = 16'h55AA;
        tick(3);
        check_status("t4");
        mm_read(5'h10);

        // Second write pulse while the first is still pending: dropped, error sticks.
        while (m_occ > 0) ff_read();
        d1 = 16'h1111;
        d2 = 16'h2222;
        ff_wr_data_id = d1;
        ff_wr_en_ih   = 1'b1;
        @(negedge clk_ir);
        ff_wr_en_ih = 1'b0;
        @(negedge clk_ir);
        check("t5_err_before", ff_err_oh, 0);
        ff_wr_data_id = d2;
        ff_wr_en_ih   = 1'b1;
        @(negedge clk_ir);
        ff_wr_en_ih = 1'b0;
        check("t5_err", ff_err_oh, 1);
        model_mem[m_wr_ptr] = d1;
        m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
        m_occ++;
        exp_err = 1'b1;
        tick(4);
        check_status("t5");
        ff_read();
        check("t5_data", ff_rd_data_od, d1);
        mm_write(5'h03, 16'h0BAD);
        check("t5_err_sticky", ff_err_oh, 1);

        // Reset during FRD2: everything returns to reset values, no late valid.
        ff_write(16'h7E57);
        ff_rd_en_ih = 1'b1;
        @(negedge clk_ir);
        ff_rd_en_ih = 1'b0;
        tick(2);
        check("t6_in_frd2", sram_oe_ol, 0);
        rst_ih = 1'b1;
        #1;
        check("t6_ce",      sram_ce_ol,     1);
        check("t6_oe",      sram_oe_ol,     1);
        check("t6_we",      sram_we_ol,     1);
        check("t6_addr",    sram_addr_od,   0);
        check("t6_empty",   ff_empty_oh,    1);
        check("t6_aempty",  ff_aempty_oh,   1);
        check("t6_full",    ff_full_oh,     0);
        check("t6_err",     ff_err_oh,      0);
        check("t6_rdvalid", ff_rd_valid_od, 0);
        check("t6_rddata",  ff_rd_data_od,  0);
        check("t6_mmdata",  mm_rd_data_od,  0);
        @(negedge clk_ir);
        rst_ih   = 1'b0;
        m_occ    = 0;
        m_wr_ptr = 0;
        m_rd_ptr = 0;
        exp_err  = 1'b0;
        vcount   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_ir);
            if (ff_rd_valid_od) vcount++;
        end
        check("t6_no_valid", vcount, 0);
        check_status("t6");

        // Fill to depth-1 so the write pointer sits at the top, then wrap and overflow.
        for (int i = 0; i < DEPTH - 1; i++) ff_write(16'($urandom));
        check("t3_ptr_top", m_wr_ptr, DEPTH - 1);
        ff_write(16'hF11F);
        check("t3_full", ff_full_oh, 1);
        ff_write(16'hDEAD);
        ff_read();
        ff_write(16'hC0DE);
        while (m_occ > 0) ff_read();
        ff_read();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
